// File: rtl/spike_scheduler_if.sv
// ----------------------------------------------------------------------------
// spike_scheduler_if
//   Bundles the timestep control, partial-sum stream and spike-vector stream
//   of the spike scheduler.
//   master : upstream/downstream environment (drives tick, sums, spike_ready)
//   slave  : the scheduler itself
//   Signals:
//     tick        timestep start pulse             (master -> slave)
//     clear_pot   zero all potentials (IDLE only)  (master -> slave)
//     threshold   firing threshold                 (master -> slave)
//     neuron_en   per-neuron spiking enable        (master -> slave)
//     sum_valid   partial sum valid                (master -> slave)
//     sum_data    partial sum for current neuron   (master -> slave)
//     sum_ready   scheduler accepts a partial sum  (slave -> master)
//     spike_valid spike vector valid               (slave -> master)
//     spike_vec   bit i = neuron i fired           (slave -> master)
//     spike_ready downstream accepts the vector    (master -> slave)
//     busy        scheduler not idle               (slave -> master)
//     overrun     tick seen while not idle (pulse) (slave -> master)
// ----------------------------------------------------------------------------
interface spike_scheduler_if #(
  parameter int NUM_NEURON      = 8,
  parameter int SUM_WIDTH       = 16,
  parameter int SPIKE_REG_WIDTH = 16
);
  logic                       tick;
  logic                       clear_pot;
  logic [SPIKE_REG_WIDTH-1:0] threshold;
  logic [NUM_NEURON-1:0]      neuron_en;
  logic                       sum_valid;
  logic [SUM_WIDTH-1:0]       sum_data;
  logic                       sum_ready;
  logic                       spike_valid;
  logic [NUM_NEURON-1:0]      spike_vec;
  logic                       spike_ready;
  logic                       busy;
  logic                       overrun;

  modport master (
    output tick, clear_pot, threshold, neuron_en, sum_valid, sum_data, spike_ready,
    input  sum_ready, spike_valid, spike_vec, busy, overrun
  );

  modport slave (
    input  tick, clear_pot, threshold, neuron_en, sum_valid, sum_data, spike_ready,
    output sum_ready, spike_valid, spike_vec, busy, overrun
  );
endinterface

// File: rtl/spike_scheduler.sv
// ----------------------------------------------------------------------------
// spike_scheduler
//   Time-multiplexed integrate-and-fire controller. One shared add/compare
//   datapath walks NUM_NEURON membrane potentials per timestep: a tick starts
//   the timestep, one partial sum per neuron is consumed in index order, and
//   the resulting spike vector is offered on a valid/ready output.
//
//   Ports:
//     clk   clock
//     rstb  asynchronous, active-high reset
//     sif   spike_scheduler_if.slave (tick/clear_pot/threshold/neuron_en,
//           sum_valid/sum_data/sum_ready, spike_valid/spike_vec/spike_ready,
//           busy, overrun)
//
//   Build option:
//     SPIKE_SCHED_RESET_TO_ZERO_EN  defined   -> firing neuron potential is
//                                              reset to zero
//                                   undefined -> subtractive reset (pot <= r)
// ----------------------------------------------------------------------------
module spike_scheduler #(
  parameter int NUM_NEURON      = 8,
  parameter int SUM_WIDTH       = 16,
  parameter int SPIKE_REG_WIDTH = 16
) (
  input logic              clk,
  input logic              rstb,
  spike_scheduler_if.slave sif
);

  localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURON - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  state_e                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [SPIKE_REG_WIDTH-1:0] pot_q [NUM_NEURON];
  logic [NUM_NEURON-1:0]      spike_acc_q;
  logic [NUM_NEURON-1:0]      spike_vec_q;
  logic                       sum_ready_q;
  logic                       spike_valid_q;
  logic                       busy_q;
  logic                       overrun_q;

  // Combinational datapath for the neuron currently addressed by idx_q.
  logic [SPIKE_REG_WIDTH-1:0] pot_cur;
  logic [SPIKE_REG_WIDTH-1:0] pot_sum;
  logic [SPIKE_REG_WIDTH-1:0] pot_res;
  logic                       fire;
  logic [SPIKE_REG_WIDTH-1:0] pot_d;
  logic [NUM_NEURON-1:0]      spike_acc_d;
  logic                       sum_hs;

  // A wrapped result with MSB clear counts as "at or above threshold".
  function automatic logic at_or_above(input logic [SPIKE_REG_WIDTH-1:0] r);
    return ~r[SPIKE_REG_WIDTH-1];
  endfunction

  // Shared accumulate/compare datapath and spike-bit merge.
  always_comb begin
    pot_cur     = pot_q[idx_q];
    pot_sum     = pot_cur + sif.sum_data;
    pot_res     = pot_sum - sif.threshold;
    fire        = sif.neuron_en[idx_q] & at_or_above(pot_res);
    pot_d       = pot_cur;
    spike_acc_d = spike_acc_q;
    spike_acc_d[idx_q] = fire;
    if (!sif.neuron_en[idx_q]) begin
      pot_d = pot_cur;           // disabled neuron: sum is dropped
    end else if (fire) begin
`ifdef SPIKE_SCHED_RESET_TO_ZERO_EN
      pot_d = '0;
`else
      pot_d = pot_res;
`endif
    end else begin
      pot_d = pot_sum;
    end
    sum_hs = sif.sum_valid & sum_ready_q;
  end

  // Control FSM with registered handshake/status outputs and potential file.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      spike_acc_q   <= '0;
      spike_vec_q   <= '0;
      sum_ready_q   <= 1'b0;
      spike_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_NEURON; i++) begin
        pot_q[i] <= '0;
      end
    end else begin
      // tick is only meaningful in IDLE; anywhere else it is flagged.
      overrun_q <= sif.tick & (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          // Clear and tick in the same cycle: clear lands first, so the
          // new timestep accumulates from zero.
          if (sif.clear_pot) begin
            for (int i = 0; i < NUM_NEURON; i++) begin
              pot_q[i] <= '0;
            end
          end
          if (sif.tick) begin
            state_q     <= S_ACCUM;
            idx_q       <= '0;
            spike_acc_q <= '0;
            sum_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (sum_hs) begin
            pot_q[idx_q] <= pot_d;
            spike_acc_q  <= spike_acc_d;
            if (idx_q == IDX_LAST) begin
              state_q       <= S_OUTPUT;
              idx_q         <= '0;
              spike_vec_q   <= spike_acc_d;
              sum_ready_q   <= 1'b0;
              spike_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (sif.spike_ready) begin
            state_q       <= S_IDLE;
            spike_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          idx_q         <= '0;
          sum_ready_q   <= 1'b0;
          spike_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign sif.sum_ready   = sum_ready_q;
  assign sif.spike_valid = spike_valid_q;
  assign sif.spike_vec   = spike_vec_q;
  assign sif.busy        = busy_q;
  assign sif.overrun     = overrun_q;

endmodule
